// File: rtl/stream_demux.sv
// One-word stream demultiplexer: a held word is delivered to one channel or
// broadcast to all, with per-channel pending bits and a delivered-word counter.
module stream_demux #(
  parameter int N  = 16,
  parameter int S  = 4,
  parameter int CW = 16,
  localparam int SW = $clog2(S)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_data,
  input  logic [SW-1:0]   in_sel,
  input  logic            in_bcast,
  output logic [S-1:0]    out_valid,
  input  logic [S-1:0]    out_ready,
  output logic [S*N-1:0]  out_data,
  output logic            sel_err,
  output logic [CW-1:0]   dlv_count
);

  typedef enum logic {EMPTY, HOLD} state_t;

  state_t         state;
  logic [S-1:0]   pend_q, pend_d;
  logic [N-1:0]   data_q;
  logic           sel_err_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [S-1:0]   hs;
  logic [S-1:0]   load_mask;
  logic           accept;
  logic           drop;

  assign state    = (pend_q != '0) ? HOLD : EMPTY;
  assign hs       = pend_q & out_ready;
  assign in_ready = (state == EMPTY) || ((pend_q & ~out_ready) == '0);
  assign accept   = in_valid && in_ready;

  // Decoding by equality leaves the mask empty for out-of-range selects,
  // which covers non-power-of-two S without a separate range compare.
  always_comb begin
    load_mask = '0;
    if (in_bcast) begin
      load_mask = '1;
    end else begin
      for (int unsigned k = 0; k < S; k++) begin
        if (in_sel == SW'(k)) load_mask[k] = 1'b1;
      end
    end
  end

  assign drop   = accept && !in_bcast && (load_mask == '0);
  assign pend_d = accept ? load_mask : (pend_q & ~hs);

  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned k = 0; k < S; k++) begin
      cnt_d = cnt_d + CW'(hs[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q    <= '0;
      data_q    <= '0;
      sel_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      if (accept) data_q <= in_data;
      if (drop) sel_err_q <= 1'b1;
    end
  end

  always_comb begin
    out_data = '0;
    for (int unsigned k = 0; k < S; k++) begin
      out_data[k*N +: N] = pend_q[k] ? data_q : '0;
    end
  end

  assign out_valid = pend_q;
  assign sel_err   = sel_err_q;
  assign dlv_count = cnt_q;

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: three instances cover S=4, S=3 and a
// narrow wrapping counter.
module tb_stream_demux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // u0: N=8 S=4 CW=16
  logic        a_iv = 1'b0, a_bc = 1'b0;
  logic [7:0]  a_id = '0;
  logic [1:0]  a_sel = '0;
  logic [3:0]  a_ordy = '0;
  logic        a_ir, a_err;
  logic [3:0]  a_ov;
  logic [31:0] a_od;
  logic [15:0] a_cnt;

  stream_demux #(.N(8), .S(4), .CW(16)) u0 (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .in_sel(a_sel), .in_bcast(a_bc), .out_valid(a_ov), .out_ready(a_ordy),
    .out_data(a_od), .sel_err(a_err), .dlv_count(a_cnt));

  // u1: N=8 S=3 CW=16
  logic        b_iv = 1'b0, b_bc = 1'b0;
  logic [7:0]  b_id = '0;
  logic [1:0]  b_sel = '0;
  logic [2:0]  b_ordy = '0;
  logic        b_ir, b_err;
  logic [2:0]  b_ov;
  logic [23:0] b_od;
  logic [15:0] b_cnt;

  stream_demux #(.N(8), .S(3), .CW(16)) u1 (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .in_sel(b_sel), .in_bcast(b_bc), .out_valid(b_ov), .out_ready(b_ordy),
    .out_data(b_od), .sel_err(b_err), .dlv_count(b_cnt));

  // u2: N=8 S=4 CW=4
  logic        c_iv = 1'b0, c_bc = 1'b0;
  logic [7:0]  c_id = '0;
  logic [1:0]  c_sel = '0;
  logic [3:0]  c_ordy = '0;
  logic        c_ir, c_err;
  logic [3:0]  c_ov;
  logic [31:0] c_od;
  logic [3:0]  c_cnt;

  stream_demux #(.N(8), .S(4), .CW(4)) u2 (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
    .in_sel(c_sel), .in_bcast(c_bc), .out_valid(c_ov), .out_ready(c_ordy),
    .out_data(c_od), .sel_err(c_err), .dlv_count(c_cnt));

  initial begin
    #1;
    check("rst_ov", a_ov, 4'b0000);
    check("rst_od", a_od, 32'h0);
    check("rst_ir", a_ir, 1'b1);
    check("rst_err", a_err, 1'b0);
    check("rst_cnt", a_cnt, 16'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // unicast 0xA5 to channel 2
    a_iv = 1'b1; a_id = 8'hA5; a_sel = 2'd2; a_bc = 1'b0; a_ordy = 4'h0;
    step();
    a_iv = 1'b0;
    check("uni_ov", a_ov, 4'b0100);
    check("uni_od", a_od, 32'h00A5_0000);
    check("uni_ir_blocked", a_ir, 1'b0);
    a_ordy = 4'hF;
    #1;
    check("uni_ir_hs", a_ir, 1'b1);
    step();
    check("uni_ov_clr", a_ov, 4'b0000);
    check("uni_cnt", a_cnt, 16'd1);

    // broadcast 0x3C drained in three partial steps
    a_ordy = 4'h0; a_iv = 1'b1; a_id = 8'h3C; a_bc = 1'b1; a_sel = 2'd3;
    step();
    a_iv = 1'b0; a_bc = 1'b0;
    check("bc_ov0", a_ov, 4'b1111);
    check("bc_od0", a_od, 32'h3C3C_3C3C);
    a_ordy = 4'b0001;
    #1;
    check("bc_ir0", a_ir, 1'b0);
    step();
    check("bc_ov1", a_ov, 4'b1110);
    check("bc_od1", a_od, 32'h3C3C_3C00);
    a_ordy = 4'b1010;
    #1;
    check("bc_ir1", a_ir, 1'b0);
    step();
    check("bc_ov2", a_ov, 4'b0100);
    check("bc_od2", a_od, 32'h003C_0000);
    a_ordy = 4'b0100;
    #1;
    check("bc_ir2", a_ir, 1'b1);
    step();
    check("bc_ov3", a_ov, 4'b0000);
    check("bc_cnt", a_cnt, 16'd5);

    // back-to-back unicast words 1..8
    a_ordy = 4'hF;
    for (int i = 1; i <= 8; i++) begin
      a_iv = 1'b1; a_id = 8'(i); a_sel = 2'((i - 1) % 4);
      #1;
      check("b2b_ir", a_ir, 1'b1);
      step();
      check("b2b_ov", a_ov, 4'b0001 << ((i - 1) % 4));
      check("b2b_od", a_od, 32'(i) << (8 * ((i - 1) % 4)));
    end
    a_iv = 1'b0;
    step();
    check("b2b_ov_end", a_ov, 4'b0000);
    check("b2b_cnt", a_cnt, 16'd13);

    // S=3: out-of-range select is dropped and flagged
    b_iv = 1'b1; b_id = 8'h55; b_sel = 2'd3; b_bc = 1'b0; b_ordy = 3'b111;
    step();
    b_iv = 1'b0;
    check("s3_drop_ov", b_ov, 3'b000);
    check("s3_err_set", b_err, 1'b1);
    b_iv = 1'b1; b_id = 8'h66; b_sel = 2'd2;
    step();
    b_iv = 1'b0;
    check("s3_ov", b_ov, 3'b100);
    check("s3_od", b_od, 24'h66_0000);
    step();
    check("s3_err_sticky", b_err, 1'b1);
    check("s3_cnt", b_cnt, 16'd1);

    // CW=4: 17 deliveries wrap the counter
    c_ordy = 4'hF;
    for (int i = 0; i < 17; i++) begin
      c_iv = 1'b1; c_id = 8'(i + 1); c_sel = 2'(i % 4);
      step();
      if (i == 15) check("cw4_allones", c_cnt, 4'hF);
    end
    c_iv = 1'b0;
    step();
    check("cw4_wrap", c_cnt, 4'd1);

    // reset during HOLD discards the held word
    a_ordy = 4'h0; a_iv = 1'b1; a_id = 8'h77; a_sel = 2'd1;
    step();
    a_iv = 1'b0;
    check("rh_ov", a_ov, 4'b0010);
    rst = 1'b1;
    #1;
    check("rh_ov_async", a_ov, 4'b0000);
    check("rh_od_async", a_od, 32'h0);
    check("rh_cnt_async", a_cnt, 16'd0);
    check("rh_err_s3", b_err, 1'b0);
    step();
    rst = 1'b0;
    a_ordy = 4'hF;
    step();
    step();
    check("rh_ov_after", a_ov, 4'b0000);
    check("rh_cnt_after", a_cnt, 16'd0);
    check("rh_ir_after", a_ir, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 SHALL have parameter N, default 16: data word width in bits.
REQ-002 SHALL have parameter S, default 4: number of output channels; S >= 2; SW = $clog2(S).
REQ-003 SHALL have parameter CW, default 16: width of the delivered-word counter.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  source word valid.
REQ-007 SHALL have port in_ready  output  1  block accepts word this cycle.
REQ-008 SHALL have port in_data  input  N  source word.
REQ-009 SHALL have port in_sel  input  SW  destination channel index; bit SW-1 is the MSB.
REQ-010 SHALL have port in_bcast  input  1  deliver word to all S channels; in_sel ignored.
REQ-011 SHALL have port out_valid  output  S  per-channel valid; bit k is channel k.
REQ-012 SHALL have port out_ready  input  S  per-channel ready.
REQ-013 SHALL have port out_data  output  S*N  channel k occupies bits [(k+1)*N-1 : k*N].
REQ-014 SHALL have port sel_err  output  1  sticky flag: non-broadcast word with in_sel >= S was accepted.
REQ-015 SHALL have port dlv_count  output  CW  count of completed channel handshakes.

Function
REQ-016 SHALL hold one word in an output register with an S-bit pending mask; states EMPTY (mask all zero) and HOLD (mask non-zero).
REQ-017 Accept = in_valid && in_ready; on accept, SHALL load the register from in_data on the next edge.
REQ-018 Pending mask load: in_bcast=1 -> all S bits set; in_bcast=0 and in_sel < S -> only bit in_sel set; in_sel >= S -> mask zero, word dropped.
REQ-019 out_valid[k] SHALL equal pending[k], driven from registers only, with no combinational path from any input.
REQ-020 out_data lane k SHALL carry the held word when pending[k]=1; otherwise it is zero.
REQ-021 Channel k handshake = out_valid[k] && out_ready[k]; SHALL clear pending[k] on the next edge.
REQ-022 in_ready SHALL equal (pending & ~out_ready) == 0, so the block accepts when EMPTY or when every remaining pending channel handshakes this cycle.
REQ-023 When the last pending handshakes and an accept occur in the same cycle, SHALL load the new mask and data with no bubble; sustained throughput is 1 word/cycle for unicast with a ready sink.
REQ-024 Broadcast channels SHALL complete independently in any order; the word stays held until all have completed; lanes already completed show out_valid=0 and zero data.
REQ-025 Latency SHALL be exactly 1 cycle from accept to out_valid assertion.
REQ-026 Held data and mask SHALL NOT change while in HOLD except for pending bits cleared per REQ-021.
REQ-027 sel_err SHALL set on the edge after a dropped accept (REQ-018) and remain set until reset; a dropped word does not change the pending mask.
REQ-028 dlv_count SHALL add the popcount of channel handshakes each cycle, modulo 2^CW, wrapping from all-ones to zero.
REQ-029 When S is not a power of two, in_sel values from S to 2^SW-1 SHALL be treated as invalid per REQ-018.

Reset
REQ-030 While rst=1, asynchronously: pending=0, held data=0, out_valid=0, out_data=0, sel_err=0, dlv_count=0; in_ready=1 follows from the empty mask.
REQ-031 Reset mid-HOLD SHALL discard the held word; no handshake is reported for it after reset releases.

Verification
REQ-032 N=8, S=4: accept 0xA5 with sel=2 -> next cycle out_valid=4'b0100, lane2=0xA5, other lanes 0; with out_ready=4'hF it clears, and dlv_count=1.
REQ-033 Broadcast 0x3C with out_ready=4'b0001, then 4'b1010, then 4'b0100 -> out_valid goes 1111, 1110, 0100, 0000; in_ready=0 until the third cycle; dlv_count=4.
REQ-034 Back-to-back unicast words 1..8 with sel=0..3 cycling and out_ready=4'hF -> one delivery per cycle, no bubbles, data order preserved, dlv_count=8.
REQ-035 S=3: accept with sel=3, in_bcast=0 -> no out_valid; sel_err=1 from the next cycle and stays set; the following valid word still delivers.
REQ-036 Assert rst during HOLD with out_ready=0 -> out_valid=0 immediately; after release, out_valid stays 0 and dlv_count=0.
REQ-037 CW=4: 17 unicast deliveries -> dlv_count=1 after wrap.
